// File: rtl/mer_sweep_ctrl.sv
// mer_sweep_ctrl: steps the matched-filter delay tap through all four phases,
// measures the accumulated squared error at each and reports the phase with
// the lowest error (earliest phase wins a tie).
module mer_sweep_ctrl #(
    parameter int WIN_LOG2 = 20,  // measurement window = 2^WIN_LOG2 symbols
    parameter int SETTLE   = 16   // symbols discarded after a phase change (1..255)
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        sym_clk_en,
    input  logic        start,
    input  logic [55:0] err_sq_in,
    output logic [1:0]  phase_sel,
    output logic        clr_acc,
    output logic        busy,
    output logic        done,
    output logic [1:0]  best_phase,
    output logic [55:0] best_err
);

    // One spare bit over the window size; SETTLE-1 must also fit in CW bits.
    localparam int              CW          = WIN_LOG2 + 1;
    localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0]   WIN_LAST    = {1'b0, {WIN_LOG2{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_CAPTURE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic [55:0]    run_min;
    logic [1:0]     cand;

    logic           cnt_clr, cnt_inc, sweep_init, phase_inc, sample, commit;

    // State register.
    always_ff @(posedge sys_clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state decode and per-state control strobes.
    always_comb begin
        state_nx   = state;
        clr_acc    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        sweep_init = 1'b0;
        phase_inc  = 1'b0;
        sample     = 1'b0;
        commit     = 1'b0;
        busy       = (state != S_IDLE) && (state != S_DONE);
        done       = (state == S_DONE);
        case (state)
            S_IDLE: begin
                if (start) begin
                    sweep_init = 1'b1;
                    cnt_clr    = 1'b1;
                    state_nx   = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (sym_clk_en) begin
                    if (cnt == SETTLE_LAST) begin
                        clr_acc  = 1'b1;
                        cnt_clr  = 1'b1;
                        state_nx = S_MEASURE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            S_MEASURE: begin
                if (sym_clk_en) begin
                    if (cnt == WIN_LAST) begin
                        clr_acc  = 1'b1;
                        cnt_clr  = 1'b1;
                        state_nx = S_CAPTURE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            // Two cycles give the averager time to present the dumped sum.
            S_CAPTURE: begin
                if (cnt[0]) begin
                    sample   = 1'b1;
                    cnt_clr  = 1'b1;
                    state_nx = S_NEXT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_NEXT: begin
                cnt_clr = 1'b1;
                if (phase_sel == 2'd3) begin
                    state_nx = S_DONE;
                end else begin
                    phase_inc = 1'b1;
                    state_nx  = S_SETTLE;
                end
            end
            S_DONE: begin
                commit   = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        // Reset wins over a strobe arriving in the same cycle.
        if (reset) clr_acc = 1'b0;
    end

    // Symbol counter, phase select, running minimum and published result.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            cnt        <= '0;
            phase_sel  <= 2'd0;
            run_min    <= '0;
            cand       <= 2'd0;
            best_phase <= 2'd0;
            best_err   <= '0;
        end else begin
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;

            if (sweep_init) begin
                phase_sel <= 2'd0;
                run_min   <= '1;
                cand      <= 2'd0;
            end else if (phase_inc) begin
                phase_sel <= phase_sel + 2'd1;
            end

            // Strict less-than keeps the earlier phase on a tie.
            if (sample && (err_sq_in < run_min)) begin
                run_min <= err_sq_in;
                cand    <= phase_sel;
            end

            if (commit) begin
                best_phase <= cand;
                best_err   <= run_min;
            end
        end
    end

endmodule

// File: tb/tb_mer_sweep_ctrl.sv
// tb_mer_sweep_ctrl: scoreboard bench. Stimulus pushes the expected sweep
// result; a negedge monitor pops and checks it when done pulses, and also
// tallies clr_acc pulses and symbol strobes per phase over each sweep.
module tb_mer_sweep_ctrl;

    localparam int WIN_LOG2 = 3;
    localparam int SETTLE   = 2;
    localparam int STROBES_PER_PHASE = SETTLE + (1 << WIN_LOG2);

    logic        sys_clk = 1'b0;
    logic        reset = 1'b1;
    logic        sym_clk_en = 1'b0;
    logic        start = 1'b0;
    logic [55:0] err_sq_in;
    logic [1:0]  phase_sel, best_phase;
    logic        clr_acc, busy, done;
    logic [55:0] best_err;

    typedef struct {
        logic [1:0]  ph;
        logic [55:0] err;
    } exp_t;

    logic [55:0] errs [4];
    exp_t        expq [$];
    int          errors = 0;
    int          checks = 0;
    bit          sym_hold = 1'b0;
    int          cyc = 0;

    mer_sweep_ctrl #(.WIN_LOG2(WIN_LOG2), .SETTLE(SETTLE)) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .sym_clk_en (sym_clk_en),
        .start      (start),
        .err_sq_in  (err_sq_in),
        .phase_sel  (phase_sel),
        .clr_acc    (clr_acc),
        .busy       (busy),
        .done       (done),
        .best_phase (best_phase),
        .best_err   (best_err)
    );

    always #5 sys_clk = ~sys_clk;

    // Downstream averager model: the error seen depends on the selected tap.
    assign err_sq_in = errs[phase_sel];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: smallest error; among equals the lowest phase.
    function automatic exp_t model();
        exp_t        e;
        logic [55:0] m;
        m = errs[0];
        for (int i = 1; i < 4; i++) if (errs[i] < m) m = errs[i];
        e.err = m;
        e.ph  = 2'd0;
        for (int i = 3; i >= 0; i--) if (errs[i] == m) e.ph = 2'(i);
        return e;
    endfunction

    // Symbol strobe every 4th cycle unless held off.
    initial forever begin
        @(posedge sys_clk);
        #1;
        cyc++;
        sym_clk_en = !sym_hold && (cyc % 4 == 0);
    end

    // Monitor / scoreboard.
    int          strobes [4];
    int          clrs = 0;
    bit          pend = 1'b0;
    bit          skip_hold = 1'b1;
    logic [57:0] prev_best = '0;
    exp_t        cur;

    always @(negedge sys_clk) begin
        if (reset) begin
            clrs = 0;
            for (int i = 0; i < 4; i++) strobes[i] = 0;
            pend = 1'b0;
            skip_hold = 1'b1;
        end else begin
            if (pend) begin
                check("best_phase", best_phase, cur.ph);
                check("best_err", best_err, cur.err);
                pend = 1'b0;
            end else if (!skip_hold && ({best_phase, best_err} !== prev_best)) begin
                check("best_hold", {best_phase, best_err}, prev_best);
            end
            skip_hold = 1'b0;
            if (clr_acc) begin
                clrs++;
                check("clr_with_sym", sym_clk_en, 1);
            end
            if (busy && sym_clk_en) strobes[phase_sel]++;
            if (done) begin
                check("busy_at_done", busy, 0);
                if (expq.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    cur = expq.pop_front();
                    pend = 1'b1;
                    check("clr_count", clrs, 8);
                    for (int i = 0; i < 4; i++)
                        check($sformatf("strobes_ph%0d", i), strobes[i], STROBES_PER_PHASE);
                end
                clrs = 0;
                for (int i = 0; i < 4; i++) strobes[i] = 0;
            end
        end
        prev_best = {best_phase, best_err};
    end

    task automatic pulse_start();
        @(posedge sys_clk); #1 start = 1'b1;
        @(posedge sys_clk); #1 start = 1'b0;
    endtask

    task automatic issue_sweep();
        expq.push_back(model());
        pulse_start();
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge sys_clk); #1;
            if (expq.size() == 0) ok = 1'b1;
        end
        if (!ok) begin
            check("sweep_timeout", 0, 1);
            expq.delete();
        end
    endtask

    // Returns in the cycle SETTLE ends for phase ph (first clr_acc of that phase).
    task automatic wait_settle_end(input logic [1:0] ph);
        bit ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge sys_clk); #1;
            if (phase_sel == ph && clr_acc) ok = 1'b1;
        end
        if (!ok) check("settle_timeout", 0, 1);
    endtask

    task automatic rand_errs();
        int mode = $urandom_range(0, 3);
        for (int i = 0; i < 4; i++) begin
            case (mode)
                0:       errs[i] = 56'($urandom_range(0, 3));
                1:       errs[i] = {24'($urandom), 32'($urandom)};
                2:       errs[i] = ($urandom_range(0, 1) != 0) ? '1 : 56'($urandom_range(0, 9));
                default: errs[i] = 56'($urandom_range(0, 1000));
            endcase
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) errs[i] = '0;
        repeat (3) @(posedge sys_clk);
        #1 reset = 1'b0;
        @(negedge sys_clk);
        check("rst_phase_sel", phase_sel, 0);
        check("rst_clr_acc", clr_acc, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_best_phase", best_phase, 0);
        check("rst_best_err", best_err, 0);

        // Distinct errors: phase 1 lowest.
        errs[0] = 40; errs[1] = 10; errs[2] = 30; errs[3] = 20;
        issue_sweep();
        wait_idle();
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("idle_phase_sel", phase_sel, 3);
        check("idle_busy", busy, 0);
        check("hold_best_phase", best_phase, 1);
        check("hold_best_err", best_err, 10);

        // All equal: earliest phase keeps the win.
        for (int i = 0; i < 4; i++) errs[i] = 25;
        issue_sweep();
        wait_idle();

        // Start during phase 2 MEASURE is ignored.
        rand_errs();
        issue_sweep();
        wait_settle_end(2'd2);
        repeat (3) @(posedge sys_clk);
        #1 start = 1'b1;
        @(posedge sys_clk); #1 start = 1'b0;
        wait_idle();

        // Strobes held off in MEASURE: nothing advances.
        rand_errs();
        issue_sweep();
        wait_settle_end(2'd1);
        sym_hold = 1'b1;
        repeat (100) @(posedge sys_clk);
        @(negedge sys_clk);
        check("hold_phase_sel", phase_sel, 1);
        check("hold_busy", busy, 1);
        sym_hold = 1'b0;
        wait_idle();

        // Reset mid-sweep aborts with everything cleared.
        rand_errs();
        issue_sweep();
        wait_settle_end(2'd1);
        repeat (5) @(posedge sys_clk);
        #1 reset = 1'b1;
        expq.delete();
        @(posedge sys_clk); #1 reset = 1'b0;
        @(negedge sys_clk);
        check("abort_phase_sel", phase_sel, 0);
        check("abort_clr_acc", clr_acc, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_best_phase", best_phase, 0);
        check("abort_best_err", best_err, 0);
        repeat (60) @(posedge sys_clk);

        // Random sweeps, some started the cycle right after done.
        for (int n = 0; n < 16; n++) begin
            rand_errs();
            if ($urandom_range(0, 1) != 0) repeat ($urandom_range(1, 9)) @(posedge sys_clk);
            issue_sweep();
            wait_idle();
        end
        repeat (4) @(posedge sys_clk);
        check("queue_empty", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
